// File: rtl/sp_ram_mp_pkg.sv
// Shared address-decode helpers and geometry derivations for the banked scratchpad.
package sp_ram_mp_pkg;

    function automatic int unsigned calc_offs_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned calc_bank_bits(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned calc_rows_per_bank(input int unsigned ram_size,
                                                       input int unsigned num_banks,
                                                       input int unsigned data_width);
        return ram_size / (num_banks * (data_width / 8));
    endfunction

    // Bank index sits directly above the byte offset so consecutive words interleave.
    function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                            input int unsigned offs_bits,
                                            input int unsigned bank_bits);
        return (addr >> offs_bits) & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr,
                                           input int unsigned offs_bits,
                                           input int unsigned bank_bits);
        return addr >> (offs_bits + bank_bits);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with byte enables; read data holds across writes and idle cycles.
module sp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2048
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      be,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rdata <= '0;
        else if (en && !we)  rdata <= mem[addr];
    end

endmodule

// File: rtl/sp_ram_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module sp_ram_rr_arb #(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt_c
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        gnt_c = '0;
        ptr_d = ptr_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                ptr_d      = PTR_W'((32'(idx) + 32'd1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sp_ram_mp_banked.sv
// Multi-port word-interleaved banked scratchpad with per-bank round-robin arbitration.
// Optional SP_RAM_BYPASS_EN adds bypass_en_i: writes are blocked and each access echoes its wdata.
module sp_ram_mp_banked
    import sp_ram_mp_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                               clk,
    input  logic                               rstn_i,
    input  logic [NUM_PORTS-1:0]               req_i,
    input  logic [NUM_PORTS-1:0]               we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
`ifdef SP_RAM_BYPASS_EN
    input  logic                               bypass_en_i,
`endif
    output logic [NUM_PORTS-1:0]               gnt_o,
    output logic [NUM_PORTS-1:0]               rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o
);

    localparam int unsigned BE_W      = DATA_WIDTH / 8;
    localparam int unsigned OFFS_BITS = calc_offs_bits(DATA_WIDTH);
    localparam int unsigned BANK_BITS = calc_bank_bits(NUM_BANKS);
    localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned ROWS      = calc_rows_per_bank(RAM_SIZE, NUM_BANKS, DATA_WIDTH);
    localparam int unsigned ROW_W     = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;

    if ((NUM_BANKS == 0) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_chk_banks
        $error("sp_ram_mp_banked: NUM_BANKS must be a power of 2");
    end
    if ((DATA_WIDTH % 8 != 0) || (RAM_SIZE % (NUM_BANKS * BE_W) != 0)) begin : g_chk_size
        $error("sp_ram_mp_banked: RAM_SIZE must be a multiple of NUM_BANKS*DATA_WIDTH/8");
    end

    logic [BANK_W-1:0]                   port_bank [NUM_PORTS];
    logic [ROW_W-1:0]                    port_row  [NUM_PORTS];
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] cand;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_gnt;
    logic [NUM_BANKS-1:0]                b_en;
    logic [NUM_BANKS-1:0]                b_we;
    logic [ROW_W-1:0]                    b_row   [NUM_BANKS];
    logic [DATA_WIDTH-1:0]               b_wdata [NUM_BANKS];
    logic [BE_W-1:0]                     b_be    [NUM_BANKS];
    logic [DATA_WIDTH-1:0]               b_rdata [NUM_BANKS];
    logic [BANK_W-1:0]                   steer_q [NUM_PORTS];
    logic                                wr_inhibit;

`ifdef SP_RAM_BYPASS_EN
    logic [NUM_PORTS-1:0]  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q [NUM_PORTS];
    assign wr_inhibit = bypass_en_i;
`else
    assign wr_inhibit = 1'b0;
`endif

    // Per-port decode and per-bank candidate vectors.
    always_comb begin
        cand = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_bank[p] = BANK_W'(bank_of(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]), OFFS_BITS, BANK_BITS));
            port_row[p]  = ROW_W'(row_of(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]), OFFS_BITS, BANK_BITS));
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cand[b][p] = req_i[p] && (port_bank[p] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sp_ram_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rstn_i),
            .req   (cand[b]),
            .gnt_c (bank_gnt[b])
        );

        sp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(ROWS)) u_ram (
            .clk   (clk),
            .rst_n (rstn_i),
            .en    (b_en[b]),
            .we    (b_we[b]),
            .addr  (b_row[b]),
            .wdata (b_wdata[b]),
            .be    (b_be[b]),
            .rdata (b_rdata[b])
        );
    end

    // Route the winning port of each bank onto that bank's RAM.
    always_comb begin
        gnt_o = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            b_en[b]    = |bank_gnt[b];
            b_we[b]    = 1'b0;
            b_row[b]   = '0;
            b_wdata[b] = '0;
            b_be[b]    = '0;
            gnt_o      = gnt_o | bank_gnt[b];
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    b_we[b]    = we_i[p] && !wr_inhibit;
                    b_row[b]   = port_row[p];
                    b_wdata[b] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    b_be[b]    = be_i[p*BE_W +: BE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_o <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) steer_q[p] <= '0;
        end else begin
            rvalid_o <= gnt_o;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (gnt_o[p]) steer_q[p] <= port_bank[p];
            end
        end
    end

`ifdef SP_RAM_BYPASS_EN
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            byp_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) byp_data_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (gnt_o[p]) begin
                    byp_q[p]      <= bypass_en_i;
                    byp_data_q[p] <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
`endif

    always_comb begin
        rdata_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
`ifdef SP_RAM_BYPASS_EN
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = byp_q[p] ? byp_data_q[p] : b_rdata[steer_q[p]];
`else
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = b_rdata[steer_q[p]];
`endif
        end
    end

endmodule

// File: tb/tb_sp_ram_mp_banked.sv
// Bench for sp_ram_mp_banked: directed vector table, reset corner cases, randomized model check.
module tb_sp_ram_mp_banked;

    localparam int NP = 2;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 15;
    localparam int BW = 4;
    localparam int NWORDS = 16;

    logic               clk = 1'b0;
    logic               rstn_i;
    logic [NP-1:0]      req_i;
    logic [NP-1:0]      we_i;
    logic [NP*AW-1:0]   addr_i;
    logic [NP*DW-1:0]   wdata_i;
    logic [NP*BW-1:0]   be_i;
    logic [NP-1:0]      gnt_o;
    logic [NP-1:0]      rvalid_o;
    logic [NP*DW-1:0]   rdata_o;
`ifdef SP_RAM_BYPASS_EN
    logic               bypass_en_i = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: flat word memory and one pointer per bank.
    logic [DW-1:0] model_mem [NWORDS];
    int            rr [NB];
    logic          c_req [NP];
    logic          c_we  [NP];
    logic [AW-1:0] c_addr [NP];
    logic [DW-1:0] c_wdata [NP];
    logic [BW-1:0] c_be [NP];

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [BW-1:0] b0, b1;
        logic [1:0]    eg;
        logic [1:0]    chk;
        logic [DW-1:0] r0, r1;
    } vec_t;

    always #5 clk = ~clk;

    sp_ram_mp_banked dut (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
`ifdef SP_RAM_BYPASS_EN
        .bypass_en_i (bypass_en_i),
`endif
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata_o[p*DW +: DW];
    endfunction

    task automatic set_port(input int p, input logic rq, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_i[p] = rq;
        we_i[p]  = w;
        addr_i[p*AW +: AW]  = a;
        wdata_i[p*DW +: DW] = d;
        be_i[p*BW +: BW]    = b;
    endtask

    task automatic idle_ports();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        idle_ports();
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) rr[b] = 0;
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                                input logic [1:0] eg, input logic [1:0] chkm,
                                input logic [DW-1:0] r0, input logic [DW-1:0] r1);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.eg = eg; v.chk = chkm; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    // One cycle of the randomized phase; expected grants come from the round-robin rule.
    task automatic model_step(input string tag, output logic [1:0] eg);
        logic [1:0]    ev;
        logic [1:0]    chkr;
        logic [DW-1:0] er [NP];
        int            win;
        int            w;
        eg = '0; ev = '0; chkr = '0;
        for (int p = 0; p < NP; p++) er[p] = '0;
        for (int b = 0; b < NB; b++) begin
            win = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (rr[b] + k) % NP;
                if (win < 0 && c_req[p] && ((int'(c_addr[p]) / 4) % NB) == b) win = p;
            end
            if (win >= 0) begin
                eg[win] = 1'b1;
                rr[b]   = (win + 1) % NP;
            end
        end
        for (int p = 0; p < NP; p++) set_port(p, c_req[p], c_we[p], c_addr[p], c_wdata[p], c_be[p]);
        #4;
        chk({tag, " gnt"}, 32'(gnt_o), 32'(eg));
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) begin
                ev[p] = 1'b1;
                if (!c_we[p]) begin
                    chkr[p] = 1'b1;
                    er[p]   = model_mem[int'(c_addr[p]) / 4];
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (eg[p] && c_we[p]) begin
                w = int'(c_addr[p]) / 4;
                for (int i = 0; i < BW; i++)
                    if (c_be[p][i]) model_mem[w][i*8 +: 8] = c_wdata[p][i*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " rvalid"}, 32'(rvalid_o), 32'(ev));
        for (int p = 0; p < NP; p++)
            if (chkr[p]) chk($sformatf("%s rdata%0d", tag, p), rd(p), er[p]);
    endtask

    initial begin
        vec_t       vecs [15];
        logic [1:0] eg;

        vecs[0]  = mk(2'b01, 2'b01, 15'h10, 15'h00, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
        vecs[1]  = mk(2'b01, 2'b01, 15'h10, 15'h00, 32'h000000AA, 32'h0, 4'h1, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
        vecs[2]  = mk(2'b10, 2'b00, 15'h00, 15'h10, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b10, 32'h0, 32'hDEADBEAA);
        vecs[3]  = mk(2'b11, 2'b11, 15'h00, 15'h04, 32'h11111111, 32'h22222222, 4'hF, 4'hF, 2'b11, 2'b00, 32'h0, 32'h0);
        vecs[4]  = mk(2'b11, 2'b00, 15'h00, 15'h04, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 2'b11, 32'h11111111, 32'h22222222);
        vecs[5]  = mk(2'b10, 2'b10, 15'h00, 15'h14, 32'h0, 32'h33333333, 4'h0, 4'hF, 2'b10, 2'b00, 32'h0, 32'h0);
        vecs[6]  = mk(2'b11, 2'b00, 15'h04, 15'h14, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b01, 32'h22222222, 32'h0);
        vecs[7]  = mk(2'b11, 2'b00, 15'h04, 15'h14, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b10, 32'h0, 32'h33333333);
        vecs[8]  = mk(2'b11, 2'b00, 15'h04, 15'h14, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b01, 32'h22222222, 32'h0);
        vecs[9]  = mk(2'b11, 2'b00, 15'h04, 15'h14, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b10, 32'h0, 32'h33333333);
        vecs[10] = mk(2'b01, 2'b01, 15'h10, 15'h00, 32'hFFFFFFFF, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
        vecs[11] = mk(2'b01, 2'b00, 15'h10, 15'h00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEAA, 32'h0);
        vecs[12] = mk(2'b10, 2'b10, 15'h00, 15'h10, 32'h0, 32'h5500CC00, 4'h0, 4'hA, 2'b10, 2'b00, 32'h0, 32'h0);
        vecs[13] = mk(2'b10, 2'b00, 15'h00, 15'h10, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b10, 32'h0, 32'h55ADCCAA);
        vecs[14] = mk(2'b00, 2'b00, 15'h00, 15'h00, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 32'h0, 32'h0);

        // Reset state with no requests.
        rstn_i = 1'b0;
        idle_ports();
        repeat (2) @(negedge clk);
        chk("reset gnt", 32'(gnt_o), 32'h0);
        chk("reset rvalid", 32'(rvalid_o), 32'h0);
        chk("reset rdata0", rd(0), 32'h0);
        chk("reset rdata1", rd(1), 32'h0);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;

        // Single uncontended read: grant same cycle, rvalid next.
        set_port(0, 1'b1, 1'b0, 15'h0, 32'h0, 4'h0);
        #4;
        chk("t1 gnt", 32'(gnt_o), 32'h1);
        @(posedge clk);
        #1;
        chk("t1 rvalid", 32'(rvalid_o), 32'h1);

        for (int i = 0; i < 15; i++) begin
            set_port(0, vecs[i].req[0], vecs[i].we[0], vecs[i].a0, vecs[i].d0, vecs[i].b0);
            set_port(1, vecs[i].req[1], vecs[i].we[1], vecs[i].a1, vecs[i].d1, vecs[i].b1);
            #4;
            chk($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vecs[i].eg));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rvalid", i), 32'(rvalid_o), 32'(vecs[i].eg));
            if (vecs[i].chk[0]) chk($sformatf("v%0d rdata0", i), rd(0), vecs[i].r0);
            if (vecs[i].chk[1]) chk($sformatf("v%0d rdata1", i), rd(1), vecs[i].r1);
        end

        // Reset in the cycle after a grant drops the pending response and restarts the pointer.
        set_port(0, 1'b1, 1'b0, 15'h04, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 15'h00, 32'h0, 4'h0);
        #4;
        chk("t5 pre gnt", 32'(gnt_o), 32'h1);
        @(posedge clk);
        #1;
        rstn_i = 1'b0;
        idle_ports();
        #1;
        chk("t5 rvalid in reset", 32'(rvalid_o), 32'h0);
        chk("t5 rdata0 in reset", rd(0), 32'h0);
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        set_port(0, 1'b1, 1'b0, 15'h04, 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b0, 15'h14, 32'h0, 4'h0);
        #4;
        chk("t5 rr restart gnt", 32'(gnt_o), 32'h1);
        @(posedge clk);
        #1;
        chk("t5 rvalid", 32'(rvalid_o), 32'h1);
        chk("t5 rdata0", rd(0), 32'h22222222);

        // Randomized phase against the flat-memory model.
        do_reset();
        for (int w = 0; w < NWORDS; w++) begin
            c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = AW'(w * 4);
            c_wdata[0] = $urandom; c_be[0] = 4'hF;
            c_req[1] = 1'b0; c_we[1] = 1'b0; c_addr[1] = '0; c_wdata[1] = '0; c_be[1] = '0;
            model_step($sformatf("init%0d", w), eg);
        end
        eg = 2'b11;
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(c_req[p] && !eg[p])) begin
                    c_req[p]   = ($urandom_range(0, 3) != 0);
                    c_we[p]    = 1'($urandom_range(0, 1));
                    c_addr[p]  = AW'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(0, 3));
                    c_wdata[p] = $urandom;
                    c_be[p]    = 4'($urandom);
                end
            end
            model_step($sformatf("rnd%0d", n), eg);
        end

`ifdef SP_RAM_BYPASS_EN
        // Bypass echoes wdata and leaves memory untouched.
        bypass_en_i = 1'b1;
        set_port(0, 1'b1, 1'b1, 15'h20, 32'h12345678, 4'hF);
        set_port(1, 1'b1, 1'b0, 15'h24, 32'hCAFEF00D, 4'h0);
        #4;
        chk("byp gnt", 32'(gnt_o), 32'h3);
        @(posedge clk);
        #1;
        chk("byp rvalid", 32'(rvalid_o), 32'h3);
        chk("byp write echo", rd(0), 32'h12345678);
        chk("byp read echo", rd(1), 32'hCAFEF00D);
        bypass_en_i = 1'b0;
        set_port(0, 1'b1, 1'b0, 15'h20, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 15'h00, 32'h0, 4'h0);
        #4;
        chk("byp off gnt", 32'(gnt_o), 32'h1);
        @(posedge clk);
        #1;
        chk("byp off old value", rd(0), model_mem[8]);
`endif

        idle_ports();
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
